prf_freelist: RTL
=================

PRF_FREELIST -- requirements
Module: prf_freelist

Interface
REQ-001 SHALL have parameter PRF_WIDTH, default 6, physical register tag width.
REQ-002 SHALL have parameter FL_DEPTH, default 32, freelist capacity; pointer width log2(FL_DEPTH) = 5.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port alloc_req, input, 4, per-slot rename request for a new destination tag; bit k is instruction k.
REQ-006 SHALL have port alloc_ready, output, 1, high when the free entries cover popcount(alloc_req).
REQ-007 SHALL have ports alloc_prd0..alloc_prd3, output, PRF_WIDTH each, tag granted to slot 0..3.
REQ-008 SHALL have port rel_v, input, 4, per-slot commit release valid, carrying the retired instruction's old mapping (preprd).
REQ-009 SHALL have ports rel_prd0..rel_prd3, input, PRF_WIDTH each, tags returned to the list.
REQ-010 SHALL have port free_count, output, 6, number of free entries, 0..32.
REQ-011 SHALL have port fl_overflow, output, 1, sticky error: a release exceeded capacity.

Function
REQ-012 SHALL hold the list as a circular FIFO: storage[FL_DEPTH] of PRF_WIDTH, a 5-bit head (next to allocate), a 5-bit tail (next to write), and a 6-bit count; pointers wrap mod 32.
REQ-013 SHALL compute n_alloc = popcount(alloc_req) and n_rel = popcount(rel_v), each 0..4.
REQ-014 SHALL drive alloc_ready = (count >= n_alloc) combinationally; alloc_ready is 1 when alloc_req = 0.
REQ-015 SHALL present alloc_prdk = storage[head + popcount(alloc_req[k-1:0])] combinationally, so granted tags are consumed in slot order with no gaps; alloc_prdk is don't-care when alloc_req[k] = 0.
REQ-016 SHALL pop all-or-nothing: when alloc_ready = 1, head advances by n_alloc at the edge; when alloc_ready = 0, nothing is popped and head holds.
REQ-017 SHALL push compacted: the j-th set bit of rel_v, in ascending slot order, writes its rel_prd to storage[tail + j]; tail advances by n_rel.
REQ-018 SHALL update count_next = count - (popped ? n_alloc : 0) + n_rel.
REQ-019 SHALL make tags released in cycle t allocatable from cycle t+1; there is no same-cycle bypass.
REQ-020 SHALL compute alloc_ready from the current count only, so it does not count same-cycle releases.
REQ-021 SHALL detect overflow when count_next > FL_DEPTH: set fl_overflow (sticky until reset), perform the pop, drop the entire release for that cycle, and leave tail unchanged.
REQ-022 SHALL drive free_count = count directly from the register.
REQ-023 SHALL handle pointer arithmetic mod 32, including offsets head+3 and tail+3 that cross entry 31 -> 0.

Reset
REQ-024 SHALL, on rst = 1 at a rising edge, load storage[i] = i + 32 for i = 0..31, head = 0, tail = 0, count = 32, and fl_overflow = 0.
REQ-025 SHALL give rst priority over any simultaneous alloc or release; a reset in the middle of traffic discards all in-flight pops and pushes.
REQ-026 SHALL show these outputs in the cycle after reset: free_count = 32, alloc_ready = 1, alloc_prd0..3 = 32, 33, 34, 35 for alloc_req = 4'b1111.

Verification
REQ-027 SHALL verify sparse alloc: after reset, alloc_req = 4'b1010 -> alloc_prd1 = 32, alloc_prd3 = 33; next cycle free_count = 30, and alloc_req = 4'b0001 -> alloc_prd0 = 34.
REQ-028 SHALL verify drain and stall: 8 cycles of alloc_req = 4'b1111 -> tags 32..63 in order, free_count = 0; a 9th request of 4'b0001 -> alloc_ready = 0, head and count unchanged.
REQ-029 SHALL verify simultaneous traffic: with free_count = 2, alloc_req = 4'b0111 and rel_v = 4'b1111 (tags 5, 6, 7, 8) in the same cycle -> alloc_ready = 0, no pop, next free_count = 6; the next alloc returns the two old entries, then 5, 6.
REQ-030 SHALL verify wrap-around: with head = tail = 30 after steady churn, release tags 1, 2, 3, 4 -> written to entries 30, 31, 0, 1 and tail = 2; later allocs return 1, 2, 3, 4 in order.
REQ-031 SHALL verify overflow: from reset (count = 32), rel_v = 4'b0001 with no alloc -> fl_overflow = 1, free_count stays 32, tail stays 0; fl_overflow stays 1 until rst.
REQ-032 SHALL verify reset mid-operation: rst asserted with alloc_req = 4'b1111 and rel_v = 4'b1111 -> next cycle free_count = 32, alloc_prd0 = 32, fl_overflow = 0.

Source files
------------

// File: rtl/prf_freelist.sv
// Physical register freelist for a 4-wide rename stage.
// The free tags are kept in a circular FIFO. Allocation pops up to four tags
// in slot order, and only when every requesting slot can be served. Commit
// pushes up to four released tags, compacted in slot order. A released tag
// can be allocated again from the following cycle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   alloc_req[3:0]             per-slot request for a new destination tag
//   alloc_ready                free entries cover popcount(alloc_req) (combinational)
//   alloc_prd0..3              tag offered to slot 0..3 (combinational)
//   rel_v[3:0], rel_prd0..3    per-slot release valid and the tag returned
//   free_count                 number of free entries (registered)
//   fl_overflow                sticky flag: a release exceeded capacity
module prf_freelist #(
    parameter int unsigned PRF_WIDTH = 6,
    parameter int unsigned FL_DEPTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                alloc_req,
    output logic                      alloc_ready,
    output logic [PRF_WIDTH-1:0]      alloc_prd0,
    output logic [PRF_WIDTH-1:0]      alloc_prd1,
    output logic [PRF_WIDTH-1:0]      alloc_prd2,
    output logic [PRF_WIDTH-1:0]      alloc_prd3,
    input  logic [3:0]                rel_v,
    input  logic [PRF_WIDTH-1:0]      rel_prd0,
    input  logic [PRF_WIDTH-1:0]      rel_prd1,
    input  logic [PRF_WIDTH-1:0]      rel_prd2,
    input  logic [PRF_WIDTH-1:0]      rel_prd3,
    output logic [$clog2(FL_DEPTH):0] free_count,
    output logic                      fl_overflow
);

    localparam int unsigned SLOTS = 4;
    localparam int unsigned PTR_W = $clog2(FL_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [PRF_WIDTH-1:0] storage [FL_DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic [PRF_WIDTH-1:0] alloc_tag [SLOTS];
    logic [PRF_WIDTH-1:0] rel_tag   [SLOTS];
    logic [2:0]           n_alloc;
    logic [2:0]           n_rel;
    logic [2:0]           pop_n;
    logic [SUM_W-1:0]     cnt_sum;
    logic                 overflow_c;

    // Number of set bits of v strictly below bit position 'upto'.
    function automatic logic [2:0] ones_below(input logic [3:0] v, input int unsigned upto);
        logic [2:0] c;
        c = 3'd0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (i < upto && v[i]) begin
                c = c + 3'd1;
            end
        end
        return c;
    endfunction

    assign rel_tag[0] = rel_prd0;
    assign rel_tag[1] = rel_prd1;
    assign rel_tag[2] = rel_prd2;
    assign rel_tag[3] = rel_prd3;

    assign alloc_prd0 = alloc_tag[0];
    assign alloc_prd1 = alloc_tag[1];
    assign alloc_prd2 = alloc_tag[2];
    assign alloc_prd3 = alloc_tag[3];

    assign free_count = count;

    // Grant/accounting logic; readiness ignores same-cycle releases.
    always_comb begin
        n_alloc     = ones_below(alloc_req, SLOTS);
        n_rel       = ones_below(rel_v, SLOTS);
        alloc_ready = (count >= CNT_W'(n_alloc));
        pop_n       = alloc_ready ? n_alloc : 3'd0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            alloc_tag[k] = storage[head + PTR_W'(ones_below(alloc_req, k))];
        end
        // One extra bit so a sum above capacity is representable.
        cnt_sum    = SUM_W'(count) - SUM_W'(pop_n) + SUM_W'(n_rel);
        overflow_c = (cnt_sum > SUM_W'(FL_DEPTH));
    end

    // FIFO state; an overflowing release is dropped whole but the pop still happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                storage[PTR_W'(i)] <= PRF_WIDTH'(i + FL_DEPTH);
            end
            head        <= '0;
            tail        <= '0;
            count       <= CNT_W'(FL_DEPTH);
            fl_overflow <= 1'b0;
        end else begin
            head <= head + PTR_W'(pop_n);
            if (overflow_c) begin
                fl_overflow <= 1'b1;
                count       <= count - CNT_W'(pop_n);
            end else begin
                count <= CNT_W'(cnt_sum);
                tail  <= tail + PTR_W'(n_rel);
                for (int unsigned k = 0; k < SLOTS; k++) begin
                    if (rel_v[k]) begin
                        storage[tail + PTR_W'(ones_below(rel_v, k))] <= rel_tag[k];
                    end
                end
            end
        end
    end

endmodule
